// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} div_state_e;

   // Widest operand the constants below can be sliced down to.
   localparam int unsigned MaxN = 64;

   localparam logic [MaxN-1:0] DIV0_Q = '1;

   // Most negative signed value of width n: only the MSB set.
   function automatic logic [MaxN-1:0] ovf_dividend(int unsigned n);
      logic [MaxN-1:0] v;
      v        = '0;
      v[n-1]   = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between EX-stage issue logic and the divider.
interface seq_divider_if #(
   parameter int unsigned N = 32
);
   logic         start;
   logic         is_signed;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract at N+1 bits, keep it if non-negative.
module div_sub_step #(
   parameter int unsigned N = 32
) (
   input  logic [N:0]   rem_shifted_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   rem_next_o,
   output logic         q_bit_o
);
   logic [N:0] trial;

   always_comb begin
      trial      = rem_shifted_i - {1'b0, divisor_i};
      q_bit_o    = ~trial[N];
      rem_next_o = q_bit_o ? trial : rem_shifted_i;
   end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider, one quotient bit per clock, RISC-V special cases.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave bus
);
   localparam int unsigned CntW = $clog2(N) + 1;
   localparam logic [N-1:0] Div0Q = DIV0_Q[N-1:0];
   localparam logic [MaxN-1:0] OvfFull = ovf_dividend(N);
   localparam logic [N-1:0] OvfDvd = OvfFull[N-1:0];

   div_state_e    state_q, state_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N:0]    rem_q, rem_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic          negq_q, negq_d;
   logic          negr_q, negr_d;
   logic [N-1:0]  quot_q, quot_d;
   logic [N-1:0]  remd_q, remd_d;

   logic          dvd_neg, dvs_neg;
   logic [N:0]    rem_shift, rem_next;
   logic          q_bit;

   assign dvd_neg   = bus.is_signed & bus.dividend[N-1];
   assign dvs_neg   = bus.is_signed & bus.divisor[N-1];
   // {rem, dvd} shifted left as one register pair.
   assign rem_shift = (rem_q << 1) | {{N{1'b0}}, dvd_q[N-1]};

   div_sub_step #(.N(N)) u_step (
      .rem_shifted_i (rem_shift),
      .divisor_i     (dvs_q),
      .rem_next_o    (rem_next),
      .q_bit_o       (q_bit)
   );

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quot_d  = quot_q;
      remd_d  = remd_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  quot_d  = Div0Q;
                  remd_d  = bus.dividend;
                  state_d = StDone;
               end else if (bus.is_signed && bus.dividend == OvfDvd && bus.divisor == '1) begin
                  quot_d  = bus.dividend;
                  remd_d  = '0;
                  state_d = StDone;
               end else begin
                  dvd_d   = dvd_neg ? -bus.dividend : bus.dividend;
                  dvs_d   = dvs_neg ? -bus.divisor : bus.divisor;
                  negq_d  = dvd_neg ^ dvs_neg;
                  negr_d  = dvd_neg;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            // Quotient bits shift into the vacated low end of the dividend register.
            rem_d = rem_next;
            dvd_d = {dvd_q[N-2:0], q_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(N - 1)) state_d = StFix;
         end
         StFix: begin
            quot_d  = negq_q ? -dvd_q : dvd_q;
            remd_d  = negr_q ? -rem_q[N-1:0] : rem_q[N-1:0];
            state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quot_q  <= '0;
         remd_q  <= '0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quot_q  <= quot_d;
         remd_q  <= remd_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StDone);
   assign bus.quotient  = quot_q;
   assign bus.remainder = remd_q;
endmodule

// File: tb/tb_seq_divider.sv
// Random and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
   localparam int N = 32;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   seq_divider_if #(.N(N)) bus ();

   seq_divider #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: RISC-V division semantics from plain integer arithmetic.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 32'd0; lat = 1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb); r = 32'(sa % sb); lat = N + 2;
      end else begin
         q = a / b; r = a % b; lat = N + 2;
      end
   endtask

   // Model timeline: m_left counts cycles of busy still to come; done when it is 1.
   int          m_left;
   logic [31:0] m_q, m_r, p_q, p_r;

   always @(posedge clk or posedge rst) begin
      int lat;
      if (rst) begin
         m_left = 0; m_q = '0; m_r = '0;
      end else if (m_left == 0) begin
         if (bus.start) begin
            model(bus.dividend, bus.divisor, bus.is_signed, p_q, p_r, lat);
            m_left = lat;
            if (lat == 1) begin m_q = p_q; m_r = p_r; end
         end
      end else begin
         m_left--;
         if (m_left == 1) begin m_q = p_q; m_r = p_r; end
      end
   end

   always @(negedge clk) begin
      chk("busy", 64'(bus.busy), 64'(m_left > 0));
      chk("done", 64'(bus.done), 64'(m_left == 1));
      if (m_left <= 1) begin
         chk("quotient", 64'(bus.quotient), 64'(m_q));
         chk("remainder", 64'(bus.remainder), 64'(m_r));
      end
   end

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      bus.dividend = a; bus.divisor = b; bus.is_signed = s; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'($urandom);
   endtask

   // Called at the negedge of cycle 1; returns the cycle in which done was seen.
   task automatic wait_done(input string nm, output int cyc);
      cyc = 1;
      while (!bus.done && cyc <= 60) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.done) begin
         chk({nm, "_timeout"}, 64'(cyc), 64'd0);
      end
   endtask

   task automatic run_dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input int elat);
      int cyc;
      start_op(a, b, s);
      wait_done(nm, cyc);
      chk({nm, "_lat"}, 64'(cyc), 64'(elat));
      chk({nm, "_q"}, 64'(bus.quotient), 64'(eq));
      chk({nm, "_r"}, 64'(bus.remainder), 64'(er));
   endtask

   function automatic logic [31:0] pick();
      unique case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(1, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] q, r;
      int lat, cyc, ndone, dcyc;
      checks = 0; failures = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;

      // Pin the model with hand-computed values.
      model(32'd100, 32'd7, 1'b0, q, r, lat);
      chk("m_100_7", {q, r}, {32'd14, 32'd2});
      chk("m_100_7_lat", 64'(lat), 64'd34);
      model(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat);
      chk("m_neg7_2", {q, r}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      model(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, lat);
      chk("m_7_neg2", {q, r}, {32'hFFFF_FFFD, 32'd1});
      model(32'd5, 32'd0, 1'b1, q, r, lat);
      chk("m_div0", {q, r, 32'(lat)}, {32'hFFFF_FFFF, 32'd5, 32'd1});
      model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat);
      chk("m_ovf", {q, r, 32'(lat)}, {32'h8000_0000, 32'd0, 32'd1});

      @(negedge clk);
      chk("rst_q", 64'(bus.quotient), 64'd0);
      chk("rst_r", 64'(bus.remainder), 64'd0);
      chk("rst_busy", 64'({bus.busy, bus.done}), 64'd0);
      rst = 1'b0;

      run_dir("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34);
      run_dir("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
      run_dir("s_7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 34);
      run_dir("u_div0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1);
      run_dir("s_div0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1);
      run_dir("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1);
      run_dir("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 34);
      run_dir("u_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 34);

      // start pulses while busy are dropped; one in the cycle after done is taken.
      start_op(32'd100, 32'd7, 1'b0);
      ndone = 0; dcyc = 0;
      for (int c = 1; c <= 35; c++) begin
         if (bus.done) begin ndone++; dcyc = c; end
         if (c == 34) begin
            chk("ign_q", 64'(bus.quotient), 64'd14);
            chk("ign_r", 64'(bus.remainder), 64'd2);
         end
         bus.start = (c == 10 || c == 34 || c == 35);
         bus.dividend = (c == 35) ? 32'd9 : 32'd50;
         bus.divisor = 32'd3;
         bus.is_signed = 1'b0;
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("ign_ndone", 64'(ndone), 64'd1);
      chk("ign_dcyc", 64'(dcyc), 64'd34);
      chk("acc35_busy", 64'(bus.busy), 64'd1);
      wait_done("acc35", cyc);
      chk("acc35_lat", 64'(cyc), 64'd34);
      chk("acc35_q", {bus.quotient, bus.remainder}, {32'd3, 32'd0});

      // Reset in the middle of CALC discards the operation.
      start_op(32'd100, 32'd7, 1'b0);
      for (int c = 1; c < 15; c++) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_flags", 64'({bus.busy, bus.done}), 64'd0);
      chk("midrst_q", 64'(bus.quotient), 64'd0);
      chk("midrst_r", 64'(bus.remainder), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_dir("post_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);

      // Random traffic; the per-cycle compare process checks every result.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic s;
         a = pick(); b = pick(); s = 1'($urandom);
         model(a, b, s, q, r, lat);
         start_op(a, b, s);
         wait_done("rand", cyc);
         chk("rand_lat", 64'(cyc), 64'(lat));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
